// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU datapath types.
//   aluop_t         - ALU opcode. Single-cycle ops 0..9, iterative ops 10..13.
//                     Codes 14 and 15 are illegal.
//   alu_mc_state_t  - handshake/iteration state of alu_mc.
//   Helper functions classify an opcode as multi-cycle, divide or signed.
package cpu_types_pkg;

  localparam int ALUOP_W = 4;

  typedef enum logic [ALUOP_W-1:0] {
    ALU_SLL  = 4'd0,
    ALU_SRL  = 4'd1,
    ALU_ADD  = 4'd2,
    ALU_SUB  = 4'd3,
    ALU_AND  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_XOR  = 4'd6,
    ALU_NOR  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9,
    ALU_MUL  = 4'd10,
    ALU_MULU = 4'd11,
    ALU_DIV  = 4'd12,
    ALU_DIVU = 4'd13
  } aluop_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } alu_mc_state_t;

  // Opcodes handled by the iterative shift-add / restoring-divide unit.
  function automatic logic isMultiOp(input logic [ALUOP_W-1:0] op);
    logic r;
    case (op)
      ALU_MUL, ALU_MULU, ALU_DIV, ALU_DIVU: r = 1'b1;
      default:                              r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic isDivOp(input logic [ALUOP_W-1:0] op);
    logic r;
    case (op)
      ALU_DIV, ALU_DIVU: r = 1'b1;
      default:           r = 1'b0;
    endcase
    return r;
  endfunction

  // Signed iterative ops: operands are made absolute and the result sign fixed up.
  function automatic logic isSignedOp(input logic [ALUOP_W-1:0] op);
    logic r;
    case (op)
      ALU_MUL, ALU_DIV: r = 1'b1;
      default:          r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_mc_iter.sv
// alu_mc_iter: iterative multiplier / divider, one bit per cycle.
//   Shift-add multiplier and restoring divider share one WIDTH+1 adder.
//   start loads absolute operands (the load cycle is the accept cycle);
//   WIDTH iterations follow. During the last iteration done=1 and hi/lo
//   present the sign-corrected result of that final step (combinational),
//   so the parent registers it on the same edge.
// Ports:
//   clk, nRST        clock, synchronous active-low reset
//   kill             abort any in-flight operation, clear the counter
//   start            load operands and begin iterating
//   op               aluop_t opcode (MUL/MULU/DIV/DIVU)
//   a, b             operand A (multiplicand/dividend), operand B
//   hi, lo           MUL: product high/low half; DIV: remainder/quotient
//   done             last iteration in progress, hi/lo valid
module alu_mc_iter
  import cpu_types_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               nRST,
  input  logic               kill,
  input  logic               start,
  input  logic [ALUOP_W-1:0] op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo,
  output logic               done
);

  localparam int CNTW = $clog2(WIDTH);

  logic [WIDTH-1:0]   acc_r;    // product high half / partial remainder
  logic [WIDTH-1:0]   sh_r;     // multiplier shifting out / dividend shifting into quotient
  logic [WIDTH-1:0]   opnd_r;   // multiplicand or divisor
  logic [CNTW-1:0]    cnt_r;
  logic               run_r;
  logic               isDiv_r;
  logic               negQ_r;   // negate product / quotient at the end
  logic               negR_r;   // negate remainder at the end
  logic               bZero_r;

  logic               sgn_s;
  logic [WIDTH-1:0]   absA_s;
  logic [WIDTH-1:0]   absB_s;
  logic [WIDTH:0]     addA_s;
  logic [WIDTH:0]     addB_s;
  logic [WIDTH+1:0]   sum_s;
  logic [WIDTH-1:0]   accNext_s;
  logic [WIDTH-1:0]   shNext_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [2*WIDTH-1:0] prodFix_s;

  // Operand sign removal for the load step.
  always_comb begin
    sgn_s  = isSignedOp(op);
    absA_s = (sgn_s && a[WIDTH-1]) ? -a : a;
    absB_s = (sgn_s && b[WIDTH-1]) ? -b : b;
  end

  // Shared adder and one iteration step. Divide uses it as a subtractor
  // (inverted divisor plus carry-in); carry-out high means the trial fits.
  always_comb begin
    if (isDiv_r) begin
      addA_s = {acc_r, sh_r[WIDTH-1]};
      addB_s = ~{1'b0, opnd_r};
    end else begin
      addA_s = {1'b0, acc_r};
      addB_s = sh_r[0] ? {1'b0, opnd_r} : '0;
    end
    sum_s = {1'b0, addA_s} + {1'b0, addB_s} + {{(WIDTH+1){1'b0}}, isDiv_r};
    if (isDiv_r) begin
      accNext_s = sum_s[WIDTH+1] ? sum_s[WIDTH-1:0] : {acc_r[WIDTH-2:0], sh_r[WIDTH-1]};
      shNext_s  = {sh_r[WIDTH-2:0], sum_s[WIDTH+1]};
    end else begin
      accNext_s = sum_s[WIDTH:1];
      shNext_s  = {sum_s[0], sh_r[WIDTH-1:1]};
    end
  end

  // Sign fix-up of the final step; divide-by-zero forces an all-ones quotient.
  always_comb begin
    prod_s    = {accNext_s, shNext_s};
    prodFix_s = negQ_r ? -prod_s : prod_s;
    if (isDiv_r) begin
      hi = negR_r ? -accNext_s : accNext_s;
      if (bZero_r) begin
        lo = '1;
      end else begin
        lo = negQ_r ? -shNext_s : shNext_s;
      end
    end else begin
      hi = prodFix_s[2*WIDTH-1:WIDTH];
      lo = prodFix_s[WIDTH-1:0];
    end
    done = run_r && (cnt_r == CNTW'(WIDTH-1));
  end

  // Working registers, iteration counter and latched sign information.
  always_ff @(posedge clk) begin
    if (!nRST) begin
      acc_r   <= '0;
      sh_r    <= '0;
      opnd_r  <= '0;
      cnt_r   <= '0;
      run_r   <= 1'b0;
      isDiv_r <= 1'b0;
      negQ_r  <= 1'b0;
      negR_r  <= 1'b0;
      bZero_r <= 1'b0;
    end else if (kill) begin
      run_r <= 1'b0;
      cnt_r <= '0;
    end else if (start) begin
      isDiv_r <= isDivOp(op);
      negQ_r  <= sgn_s && (a[WIDTH-1] ^ b[WIDTH-1]);
      negR_r  <= sgn_s && a[WIDTH-1] && isDivOp(op);
      bZero_r <= (b == '0);
      acc_r   <= '0;
      sh_r    <= isDivOp(op) ? absA_s : absB_s;
      opnd_r  <= isDivOp(op) ? absB_s : absA_s;
      cnt_r   <= '0;
      run_r   <= 1'b1;
    end else if (run_r) begin
      acc_r <= accNext_s;
      sh_r  <= shNext_s;
      cnt_r <= cnt_r + CNTW'(1);
      if (cnt_r == CNTW'(WIDTH-1)) begin
        run_r <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with valid/ready handshake, sits in EX.
//   Single-cycle ops (SLL..SLTU) return one cycle after accept; MUL/MULU/
//   DIV/DIVU run in alu_mc_iter and return WIDTH+1 cycles after accept.
//   The result register holds until the consumer takes it.
// Ports:
//   CLK, nRST              clock, synchronous active-low reset
//   flush                  abort in-flight op, drop held result (out_valid)
//   in_valid / in_ready    operand handshake; ready only in IDLE
//   ALUOP, portA, portB    opcode and operands (shamt = portB[log2 WIDTH-1:0])
//   out_valid / out_ready  result handshake
//   portOut, portHi        result low / high (MUL high half, DIV remainder)
//   neg_flag, zero_flag    sign and zero of portOut
//   of_flag                signed overflow (ADD/SUB, DIV MIN_INT/-1)
//   dz_flag                divide by zero (DIV/DIVU)
module alu_mc
  import cpu_types_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OPW   = ALUOP_W
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   ALUOP,
  input  logic [WIDTH-1:0] portA,
  input  logic [WIDTH-1:0] portB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] portOut,
  output logic [WIDTH-1:0] portHi,
  output logic             neg_flag,
  output logic             zero_flag,
  output logic             of_flag,
  output logic             dz_flag
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

  alu_mc_state_t    state_r, stateNext_s;
  logic             inReady_r, outValid_r;
  logic [WIDTH-1:0] outLo_r, outHi_r;
  logic             neg_r, zero_r, of_r, dz_r;
  logic             dzPend_r, ofPend_r;

  logic             accept_s;
  logic             isMulti_s;
  logic [SHW-1:0]   shamt_s;
  logic [WIDTH-1:0] addSum_s, subDiff_s, scRes_s;
  logic             scOf_s, scLegal_s;
  logic [WIDTH-1:0] iterHi_s, iterLo_s;
  logic             iterDone_s;

  assign in_ready  = inReady_r;
  assign out_valid = outValid_r;
  assign portOut   = outLo_r;
  assign portHi    = outHi_r;
  assign neg_flag  = neg_r;
  assign zero_flag = zero_r;
  assign of_flag   = of_r;
  assign dz_flag   = dz_r;

  assign isMulti_s = isMultiOp(ALUOP);
  assign accept_s  = in_valid && (state_r == IDLE) && !flush;
  assign shamt_s   = portB[SHW-1:0];

  // Single-cycle datapath; illegal opcodes give a zero result with no flags.
  always_comb begin
    addSum_s  = portA + portB;
    subDiff_s = portA - portB;
    scRes_s   = '0;
    scOf_s    = 1'b0;
    scLegal_s = 1'b1;
    case (ALUOP)
      ALU_SLL:  scRes_s = portA << shamt_s;
      ALU_SRL:  scRes_s = portA >> shamt_s;
      ALU_ADD: begin
        scRes_s = addSum_s;
        scOf_s  = (portA[WIDTH-1] == portB[WIDTH-1]) && (addSum_s[WIDTH-1] != portA[WIDTH-1]);
      end
      ALU_SUB: begin
        scRes_s = subDiff_s;
        scOf_s  = (portA[WIDTH-1] != portB[WIDTH-1]) && (subDiff_s[WIDTH-1] != portA[WIDTH-1]);
      end
      ALU_AND:  scRes_s = portA & portB;
      ALU_OR:   scRes_s = portA | portB;
      ALU_XOR:  scRes_s = portA ^ portB;
      ALU_NOR:  scRes_s = ~(portA | portB);
      ALU_SLT:  scRes_s = {{(WIDTH-1){1'b0}}, ($signed(portA) < $signed(portB))};
      ALU_SLTU: scRes_s = {{(WIDTH-1){1'b0}}, (portA < portB)};
      default:  scLegal_s = 1'b0;
    endcase
  end

  // Next-state logic; flush wins over accept and over a result transfer.
  always_comb begin
    stateNext_s = state_r;
    if (flush) begin
      stateNext_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            stateNext_s = isMulti_s ? BUSY : DONE;
          end else begin
            stateNext_s = IDLE;
          end
        end
        BUSY: begin
          if (iterDone_s) begin
            stateNext_s = DONE;
          end else begin
            stateNext_s = BUSY;
          end
        end
        DONE: begin
          if (out_ready) begin
            stateNext_s = IDLE;
          end else begin
            stateNext_s = DONE;
          end
        end
        default: stateNext_s = IDLE;
      endcase
    end
  end

  // State register with handshake outputs registered from the next state.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_r    <= IDLE;
      inReady_r  <= 1'b1;
      outValid_r <= 1'b0;
    end else begin
      state_r    <= stateNext_s;
      inReady_r  <= (stateNext_s == IDLE);
      outValid_r <= (stateNext_s == DONE);
    end
  end

  // Divide flags are known at accept; held until the iterative result lands.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      dzPend_r <= 1'b0;
      ofPend_r <= 1'b0;
    end else if (accept_s) begin
      dzPend_r <= isDivOp(ALUOP) && (portB == '0);
      ofPend_r <= (ALUOP == ALU_DIV) && (portA == MIN_INT) && (portB == '1);
    end
  end

  // Result and flag registers; they hold after a transfer or a flush.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      outLo_r <= '0;
      outHi_r <= '0;
      neg_r   <= 1'b0;
      zero_r  <= 1'b0;
      of_r    <= 1'b0;
      dz_r    <= 1'b0;
    end else if (accept_s && !isMulti_s) begin
      outLo_r <= scRes_s;
      outHi_r <= '0;
      neg_r   <= scRes_s[WIDTH-1];
      zero_r  <= scLegal_s && (scRes_s == '0);
      of_r    <= scOf_s;
      dz_r    <= 1'b0;
    end else if ((state_r == BUSY) && iterDone_s && !flush) begin
      outLo_r <= iterLo_s;
      outHi_r <= iterHi_s;
      neg_r   <= iterLo_s[WIDTH-1];
      zero_r  <= (iterLo_s == '0);
      of_r    <= ofPend_r;
      dz_r    <= dzPend_r;
    end
  end

  alu_mc_iter #(
    .WIDTH(WIDTH)
  ) uIter (
    .clk   (CLK),
    .nRST  (nRST),
    .kill  (flush),
    .start (accept_s && isMulti_s),
    .op    (ALUOP),
    .a     (portA),
    .b     (portB),
    .hi    (iterHi_s),
    .lo    (iterLo_s),
    .done  (iterDone_s)
  );

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc (WIDTH=32) with hand-computed expectations.
module tb_alu_mc;
  import cpu_types_pkg::*;

  logic        CLK = 1'b0;
  logic        nRST, flush, in_valid, in_ready, out_valid, out_ready;
  logic [3:0]  ALUOP;
  logic [31:0] portA, portB, portOut, portHi;
  logic        neg_flag, zero_flag, of_flag, dz_flag;

  int nVec = 0;
  int nMis = 0;

  alu_mc #(.WIDTH(32), .OPW(4)) dut (
    .CLK(CLK), .nRST(nRST), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .ALUOP(ALUOP), .portA(portA), .portB(portB),
    .out_valid(out_valid), .out_ready(out_ready),
    .portOut(portOut), .portHi(portHi),
    .neg_flag(neg_flag), .zero_flag(zero_flag), .of_flag(of_flag), .dz_flag(dz_flag)
  );

  always #5 CLK = ~CLK;

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nVec++;
    if (obs !== exp) begin
      nMis++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Counts cycles from the accept cycle until out_valid, bounded.
  task automatic waitValid(output int lat, output int rdyHits);
    lat = 1;
    rdyHits = 0;
    while (!out_valid && lat < 100) begin
      if (in_ready) rdyHits++;
      tick();
      lat++;
    end
  endtask

  task automatic vec(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] expLo, input logic [31:0] expHi, input logic [3:0] expFl,
                     input int expLat, input int hold);
    int lat, rdyHits;
    ALUOP = op; portA = a; portB = b; in_valid = 1'b1;
    checkVal({tag, "/ready"}, in_ready, 1);
    tick();
    in_valid = 1'b0;
    waitValid(lat, rdyHits);
    checkVal({tag, "/lat"}, lat, expLat);
    checkVal({tag, "/busyReady"}, rdyHits, 0);
    checkVal({tag, "/result"}, {portHi, portOut}, {expHi, expLo});
    checkVal({tag, "/flags"}, {neg_flag, zero_flag, of_flag, dz_flag}, expFl);
    for (int k = 0; k < hold; k++) begin
      tick();
      checkVal({tag, "/hold"}, {out_valid, in_ready, portOut, neg_flag, zero_flag, of_flag, dz_flag},
               {1'b1, 1'b0, expLo, expFl});
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkVal({tag, "/release"}, {out_valid, in_ready, portOut}, {1'b0, 1'b1, expLo});
  endtask

  initial begin
    int lat, hits;
    nRST = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    ALUOP = 4'd0; portA = 32'd0; portB = 32'd0;
    repeat (2) @(posedge CLK);
    #1;
    nRST = 1'b1;
    checkVal("reset/ctl", {in_ready, out_valid, neg_flag, zero_flag, of_flag, dz_flag}, 6'b100000);
    checkVal("reset/data", {portHi, portOut}, 64'd0);

    vec("add_of",  ALU_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 32'h0, 4'b1010, 1, 0);
    vec("mul_neg", ALU_MUL,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFF1, 32'hFFFFFFFF, 4'b1000, 33, 0);
    vec("divu_dz", ALU_DIVU, 32'h00000007, 32'h00000000, 32'hFFFFFFFF, 32'h00000007, 4'b1001, 33, 0);
    vec("div_ovf", ALU_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 4'b1010, 33, 0);
    vec("div_neg", ALU_DIV,  32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 32'hFFFFFFFF, 4'b1000, 33, 5);

    // No accept while in DONE, even with out_ready high.
    ALUOP = ALU_DIVU; portA = 32'd9; portB = 32'd2; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    waitValid(lat, hits);
    checkVal("divu9/lat", lat, 33);
    checkVal("divu9/result", {portHi, portOut}, {32'd1, 32'd4});
    ALUOP = ALU_ADD; portA = 32'd1; portB = 32'd1; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkVal("done_noaccept", {out_valid, in_ready, portOut}, {1'b0, 1'b1, 32'd4});
    tick();
    in_valid = 1'b0;
    checkVal("accept_after_done", {out_valid, in_ready, portOut}, {1'b1, 1'b0, 32'd2});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Flush at iteration 10 of DIVU.
    ALUOP = ALU_DIVU; portA = 32'd100; portB = 32'd3; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (10) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checkVal("flush/ctl", {out_valid, in_ready}, 2'b01);
    hits = 0;
    repeat (40) begin
      tick();
      if (out_valid) hits++;
    end
    checkVal("flush/novalid", hits, 0);
    // Flush overrides a same-cycle accept.
    ALUOP = ALU_ADD; portA = 32'd7; portB = 32'd7; in_valid = 1'b1; flush = 1'b1;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    checkVal("flush_accept", {out_valid, in_ready, portOut}, {1'b0, 1'b1, 32'd2});
    tick();
    checkVal("flush_accept2", out_valid, 0);
    vec("sub_neg", ALU_SUB, 32'd5, 32'd7, 32'hFFFFFFFE, 32'h0, 4'b1000, 1, 0);

    // Reset pulse mid-MUL.
    ALUOP = ALU_MUL; portA = 32'hFFFFFFFD; portB = 32'd5; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    nRST = 1'b0;
    tick();
    nRST = 1'b1;
    checkVal("rst_mid/data", {portHi, portOut}, 64'd0);
    checkVal("rst_mid/ctl", {out_valid, in_ready, neg_flag, zero_flag, of_flag, dz_flag}, 6'b010000);
    hits = 0;
    repeat (40) begin
      tick();
      if (out_valid) hits++;
    end
    checkVal("rst_mid/novalid", hits, 0);

    // Op mix with varying back-pressure.
    vec("sll31",   ALU_SLL,  32'h00000001, 32'h0000001F, 32'h80000000, 32'h0, 4'b1000, 1, 0);
    vec("sll_amt", ALU_SLL,  32'h00000001, 32'h00000021, 32'h00000002, 32'h0, 4'b0000, 1, 1);
    vec("srl",     ALU_SRL,  32'h80000000, 32'h00000004, 32'h08000000, 32'h0, 4'b0000, 1, 2);
    vec("and",     ALU_AND,  32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 32'h0, 4'b0000, 1, 0);
    vec("or",      ALU_OR,   32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0, 32'h0, 4'b1000, 1, 1);
    vec("xor",     ALU_XOR,  32'hF0F0F0F0, 32'h0FF00FF0, 32'hFF00FF00, 32'h0, 4'b1000, 1, 2);
    vec("nor",     ALU_NOR,  32'h0F0F0F0F, 32'h00000000, 32'hF0F0F0F0, 32'h0, 4'b1000, 1, 0);
    vec("slt",     ALU_SLT,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 32'h0, 4'b0000, 1, 1);
    vec("sltu",    ALU_SLTU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h0, 4'b0100, 1, 2);
    vec("sub_of",  ALU_SUB,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 32'h0, 4'b0010, 1, 0);
    vec("add_zero",ALU_ADD,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h0, 4'b0100, 1, 1);
    vec("mulu",    ALU_MULU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 4'b0000, 33, 2);
    vec("mul_min", ALU_MUL,  32'h80000000, 32'h80000000, 32'h00000000, 32'h40000000, 4'b0100, 33, 0);
    vec("divu",    ALU_DIVU, 32'd100,      32'd7,        32'd14,       32'd2,        4'b0000, 33, 1);
    vec("div_negb",ALU_DIV,  32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,        4'b1000, 33, 2);
    vec("illegal", 4'd14,    32'd5,        32'd3,        32'd0,        32'd0,        4'b0000, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, %0d vectors applied", nVec);
    $fatal(1);
  end

endmodule
